// File: rtl/strategy_config.sv
// Strategy configuration block: host command bytes fill shadow registers,
// which are copied to the active outputs on a frame boundary after commit.
package strategy_pkg;
  typedef struct packed {
    logic [3:0] mode;
    logic [7:0] gain;
    logic [7:0] offset;
  } parameters_t;
endpackage

module strategy_config
  import strategy_pkg::*;
#(
  parameter int NUM_STRATEGIES = 3,
  parameter int TIMEOUT        = 65535,
  parameter int PAR_BYTES      = ($bits(parameters_t) + 7) / 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        frame_start,
  input  logic        err_clr,
  output logic [7:0]  strategy_sel,
  output parameters_t par,
  output logic        applied,
  output logic [7:0]  commit_cnt,
  output logic [2:0]  err
);

  localparam int PW = $bits(parameters_t);
  localparam int SW = PAR_BYTES * 8;
  localparam logic [8:0]  NS_LIM   = 9'(NUM_STRATEGIES);
  localparam logic [8:0]  PB_LIM   = 9'(PAR_BYTES);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_SEL,
    GET_ADDR,
    GET_DATA,
    WAIT_COMMIT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  sel_sh_q, sel_sh_d;
  parameters_t par_sh_q, par_sh_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  sel_q, sel_d;
  parameters_t par_q, par_d;
  logic        applied_q, applied_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  err_q, err_d;
  logic [2:0]  err_set;
  logic [SW-1:0] wide;
  logic        xfer;

  assign cmd_ready    = (state_q != WAIT_COMMIT);
  assign xfer         = cmd_valid && cmd_ready;
  assign strategy_sel = sel_q;
  assign par          = par_q;
  assign applied      = applied_q;
  assign commit_cnt   = cnt_q;
  assign err          = err_q;

  always_comb begin
    state_d   = state_q;
    sel_sh_d  = sel_sh_q;
    par_sh_d  = par_sh_q;
    addr_d    = addr_q;
    tmo_d     = tmo_q;
    sel_d     = sel_q;
    par_d     = par_q;
    applied_d = 1'b0;
    cnt_d     = cnt_q;
    err_set   = 3'b000;
    wide      = '0;
    wide[PW-1:0] = par_sh_q;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          unique case (1'b1)
            (cmd_data == 8'h01): state_d = GET_SEL;
            (cmd_data == 8'h02): state_d = GET_ADDR;
            (cmd_data == 8'h03): begin
              state_d = WAIT_COMMIT;
              tmo_d   = 16'd0;
            end
            default: err_set[0] = 1'b1;
          endcase
        end
      end
      GET_SEL: begin
        if (xfer) begin
          if ({1'b0, cmd_data} < NS_LIM) begin
            sel_sh_d = cmd_data;
          end else begin
            err_set[1] = 1'b1;
          end
          state_d = IDLE;
        end
      end
      GET_ADDR: begin
        if (xfer) begin
          addr_d  = cmd_data;
          state_d = GET_DATA;
        end
      end
      GET_DATA: begin
        if (xfer) begin
          if ({1'b0, addr_q} < PB_LIM) begin
            for (int i = 0; i < PAR_BYTES; i++) begin
              if (addr_q == 8'(i)) wide[i*8 +: 8] = cmd_data;
            end
            par_sh_d = wide[PW-1:0];
          end else begin
            err_set[1] = 1'b1;
          end
          state_d = IDLE;
        end
      end
      WAIT_COMMIT: begin
        // A frame boundary wins over a coincident timeout expiry.
        if (frame_start) begin
          sel_d     = sel_sh_q;
          par_d     = par_sh_q;
          applied_d = 1'b1;
          cnt_d     = cnt_q + 8'd1;
          state_d   = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_set[2] = 1'b1;
          state_d    = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = (err_q & ~{3{err_clr}}) | err_set;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sel_sh_q  <= 8'd0;
      par_sh_q  <= '0;
      addr_q    <= 8'd0;
      tmo_q     <= 16'd0;
      sel_q     <= 8'd0;
      par_q     <= '0;
      applied_q <= 1'b0;
      cnt_q     <= 8'd0;
      err_q     <= 3'b000;
    end else begin
      state_q   <= state_d;
      sel_sh_q  <= sel_sh_d;
      par_sh_q  <= par_sh_d;
      addr_q    <= addr_d;
      tmo_q     <= tmo_d;
      sel_q     <= sel_d;
      par_q     <= par_d;
      applied_q <= applied_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_strategy_config.sv
// Directed bench for strategy_config: command decode, commit timing,
// error stickiness, timeout, counter wrap and reset abort.
module tb_strategy_config;
  import strategy_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        frame_start = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  strategy_sel;
  parameters_t par;
  logic        applied;
  logic [7:0]  commit_cnt;
  logic [2:0]  err;

  int vectors = 0;
  int miscompares = 0;
  int ncommit = 0;

  strategy_config #(.TIMEOUT(10)) dut (
    .clock(clock), .reset(reset),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .frame_start(frame_start),
    .err_clr(err_clr), .strategy_sel(strategy_sel),
    .par(par), .applied(applied),
    .commit_cnt(commit_cnt), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic frame();
    @(negedge clock);
    frame_start = 1'b1;
    @(posedge clock);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_sel", 32'(strategy_sel), 32'h0);
    chk("rst_par", 32'(par), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h1);
    chk("rst_applied", 32'(applied), 32'h0);
    chk("rst_cnt", 32'(commit_cnt), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // select strategy 2 and commit 5 cycles later
    send(8'h01);
    send(8'h02);
    send(8'h03);
    chk("wait_ready", 32'(cmd_ready), 32'h0);
    chk("wait_sel", 32'(strategy_sel), 32'h0);
    idle(4);
    chk("wait_ready2", 32'(cmd_ready), 32'h0);
    frame();
    ncommit++;
    chk("c1_sel", 32'(strategy_sel), 32'h2);
    chk("c1_applied", 32'(applied), 32'h1);
    chk("c1_cnt", 32'(commit_cnt), 32'h1);
    chk("c1_ready", 32'(cmd_ready), 32'h1);
    idle(1);
    chk("c1_pulse_end", 32'(applied), 32'h0);

    // par byte 0, frame_start coincident with commit opcode is ignored
    send(8'h02);
    send(8'h00);
    send(8'hA5);
    @(negedge clock);
    cmd_data    = 8'h03;
    cmd_valid   = 1'b1;
    frame_start = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid   = 1'b0;
    frame_start = 1'b0;
    idle(1);
    chk("same_applied", 32'(applied), 32'h0);
    chk("same_par", 32'(par), 32'h0);
    chk("same_ready", 32'(cmd_ready), 32'h0);
    idle(1);
    frame();
    ncommit++;
    chk("c2_par", 32'(par), 32'h000A5);
    chk("c2_applied", 32'(applied), 32'h1);
    chk("c2_cnt", 32'(commit_cnt), 32'h2);

    // bad sel, bad address, bad opcode
    send(8'h01);
    send(8'h07);
    chk("badsel_err", 32'(err), 32'h2);
    send(8'h02);
    send(8'h03);
    send(8'h11);
    send(8'h55);
    chk("err_011", 32'(err), 32'h3);
    chk("err_sel_kept", 32'(strategy_sel), 32'h2);
    chk("err_idle_ready", 32'(cmd_ready), 32'h1);
    @(negedge clock);
    err_clr = 1'b1;
    @(posedge clock);
    #1;
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'h0);
    // set event coincident with clear keeps the bit
    @(negedge clock);
    cmd_data  = 8'h66;
    cmd_valid = 1'b1;
    err_clr   = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    err_clr   = 1'b0;
    chk("set_wins", 32'(err), 32'h1);

    // top byte truncated to 4 bits, middle byte, sel unchanged
    send(8'h02);
    send(8'h02);
    send(8'hFF);
    send(8'h02);
    send(8'h01);
    send(8'h3C);
    send(8'h03);
    frame();
    ncommit++;
    chk("c3_par", 32'(par), 32'hF3CA5);
    chk("c3_sel", 32'(strategy_sel), 32'h2);
    chk("c3_cnt", 32'(commit_cnt), 32'h3);

    // timeout after 10 cycles
    @(negedge clock);
    err_clr = 1'b1;
    @(posedge clock);
    #1;
    err_clr = 1'b0;
    send(8'h03);
    idle(9);
    chk("tmo_pre_err", 32'(err), 32'h0);
    chk("tmo_pre_ready", 32'(cmd_ready), 32'h0);
    idle(1);
    chk("tmo_err", 32'(err), 32'h4);
    chk("tmo_ready", 32'(cmd_ready), 32'h1);
    chk("tmo_par", 32'(par), 32'hF3CA5);
    chk("tmo_cnt", 32'(commit_cnt), 32'h3);
    chk("tmo_applied", 32'(applied), 32'h0);
    frame();
    chk("idle_frame", 32'(applied), 32'h0);
    chk("idle_frame_cnt", 32'(commit_cnt), 32'h3);
    @(negedge clock);
    err_clr = 1'b1;
    @(posedge clock);
    #1;
    err_clr = 1'b0;
    chk("tmo_clr", 32'(err), 32'h0);

    // frame_start on the expiry cycle wins
    send(8'h03);
    idle(9);
    frame();
    ncommit++;
    chk("edge_applied", 32'(applied), 32'h1);
    chk("edge_err", 32'(err), 32'h0);
    chk("edge_cnt", 32'(commit_cnt), 32'h4);

    // commit counter wrap
    while (ncommit < 255) begin
      send(8'h03);
      frame();
      ncommit++;
    end
    chk("cnt_255", 32'(commit_cnt), 32'hFF);
    send(8'h03);
    frame();
    chk("cnt_wrap", 32'(commit_cnt), 32'h0);

    // reset in GET_DATA aborts the command
    send(8'h77);
    send(8'h02);
    send(8'h01);
    @(negedge clock);
    reset = 1'b0;
    #2;
    chk("ar_sel", 32'(strategy_sel), 32'h0);
    chk("ar_par", 32'(par), 32'h0);
    chk("ar_ready", 32'(cmd_ready), 32'h1);
    chk("ar_applied", 32'(applied), 32'h0);
    chk("ar_cnt", 32'(commit_cnt), 32'h0);
    chk("ar_err", 32'(err), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    send(8'h01);
    send(8'h01);
    send(8'h03);
    frame();
    chk("pr_sel", 32'(strategy_sel), 32'h1);
    chk("pr_par", 32'(par), 32'h0);
    chk("pr_cnt", 32'(commit_cnt), 32'h1);
    chk("pr_err", 32'(err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
